mod10_counter: RTL and testbench

//   Free-running synchronous decimal (mod-10) counter: counts 0..9, wraps to 0.

---
 rtl/mod10_counter.sv | 64 ++++++
 tb/tb_mod10_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mod10_counter.sv
// Free-running synchronous mod-N (default decimal) counter with terminal-count flag.
// Define COUNTER_MOD10_SEG7_EN to add the seg_out seven-segment decoder port.
module mod10_counter #(
    parameter int MODULUS     = 10,
    parameter int WIDTH       = 4,
    parameter int RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_out
`ifdef COUNTER_MOD10_SEG7_EN
    ,
    output logic [6:0]       seg_out
`endif
);

    localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Anything not strictly below the terminal value (wrap, upset, X) reloads 0.
    always_comb begin
        count_d = '0;
        if (count_q < TC_VAL) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;
    assign tc_out    = (count_q == TC_VAL);

`ifdef COUNTER_MOD10_SEG7_EN
    // Segment order {g,f,e,d,c,b,a}, active high; non-decimal values blank.
    always_comb begin
        seg_out = 7'h00;
        case (count_q)
            WIDTH'(0): seg_out = 7'h3F;
            WIDTH'(1): seg_out = 7'h06;
            WIDTH'(2): seg_out = 7'h5B;
            WIDTH'(3): seg_out = 7'h4F;
            WIDTH'(4): seg_out = 7'h66;
            WIDTH'(5): seg_out = 7'h6D;
            WIDTH'(6): seg_out = 7'h7D;
            WIDTH'(7): seg_out = 7'h07;
            WIDTH'(8): seg_out = 7'h7F;
            WIDTH'(9): seg_out = 7'h6F;
            default:   seg_out = 7'h00;
        endcase
    end
`endif

endmodule

// File: tb/tb_mod10_counter.sv
// Directed self-checking bench for mod10_counter; seven-segment checks only
// when COUNTER_MOD10_SEG7_EN is defined.
module tb_mod10_counter;

    logic       clk;
    logic       reset;
    logic [3:0] count_out;
    logic       tc_out;
`ifdef COUNTER_MOD10_SEG7_EN
    logic [6:0] seg_out;
`endif

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    mod10_counter #(
        .MODULUS     (10),
        .WIDTH       (4),
        .RESET_VALUE (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .count_out (count_out),
        .tc_out    (tc_out)
`ifdef COUNTER_MOD10_SEG7_EN
        ,
        .seg_out   (seg_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (count_out !== 4'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", count_out);
        end
        checks++;
        if (tc_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_tc: got %b expected 0", tc_out);
        end
        reset = 1'b0;
        @(negedge clk);
        exp_count = 1;
        checks++;
        if (count_out !== 4'd1) begin
            errors++;
            $display("FAIL first_count: got %0d expected 1", count_out);
        end
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            exp_count = (exp_count + 1) % 10;
            checks++;
            if (count_out !== 4'(exp_count)) begin
                errors++;
                $display("FAIL free_count[%0d]: got %0d expected %0d", i, count_out, exp_count);
            end
            checks++;
            if (tc_out !== (exp_count == 9)) begin
                errors++;
                $display("FAIL free_tc[%0d]: got %b expected %b at count %0d",
                         i, tc_out, (exp_count == 9), exp_count);
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 10 && exp_count != 6; i++) begin
            @(negedge clk);
            exp_count = (exp_count + 1) % 10;
        end
        checks++;
        if (count_out !== 4'd6) begin
            errors++;
            $display("FAIL mid_pre: got %0d expected 6", count_out);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (count_out !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: got %0d expected 0", count_out);
        end
        reset = 1'b0;
        @(negedge clk);
        exp_count = 1;
        checks++;
        if (count_out !== 4'd1) begin
            errors++;
            $display("FAIL mid_after: got %0d expected 1", count_out);
        end
    endtask

    task automatic test_reset_hold();
        repeat (4) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (count_out !== 4'd0 || tc_out !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got count=%0d tc=%b expected count=0 tc=0",
                         i, count_out, tc_out);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        exp_count = 1;
        checks++;
        if (count_out !== 4'd1) begin
            errors++;
            $display("FAIL hold_release: got %0d expected 1", count_out);
        end
    endtask

    task automatic test_back_to_back_wrap();
        // From 1, eight edges reach 9, the ninth wraps to 0.
        repeat (8) @(negedge clk);
        checks++;
        if (count_out !== 4'd9 || tc_out !== 1'b1) begin
            errors++;
            $display("FAIL wrap_nine: got count=%0d tc=%b expected count=9 tc=1", count_out, tc_out);
        end
        @(negedge clk);
        checks++;
        if (count_out !== 4'd0 || tc_out !== 1'b0) begin
            errors++;
            $display("FAIL wrap_zero: got count=%0d tc=%b expected count=0 tc=0", count_out, tc_out);
        end
        exp_count = 0;
    endtask

`ifdef COUNTER_MOD10_SEG7_EN
    task automatic test_seg();
        logic [6:0] seg_tbl [10];
        seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (seg_out !== seg_tbl[exp_count]) begin
                errors++;
                $display("FAIL seg[%0d]: got %h expected %h", exp_count, seg_out, seg_tbl[exp_count]);
            end
            @(negedge clk);
            exp_count = (exp_count + 1) % 10;
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
        test_free_run();
        test_mid_reset();
        test_reset_hold();
        test_back_to_back_wrap();
`ifdef COUNTER_MOD10_SEG7_EN
        test_seg();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
